color_sensor_ctrl: RTL
======================

COLOR_SENSOR_CTRL -- requirements
Module: color_sensor_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of every per-channel edge counter.
REQ-002 Parameter GATE_CYCLES, default 50000: clk cycles per measurement window.
REQ-003 Parameter SETTLE_CYCLES, default 1000: clk cycles of dead time after each filter change.
REQ-004 Parameter SCALE_SEL, default 2'b01: sensor output scaling driven during operation (20%).
REQ-005 Parameter MIN_CNT, default 24: minimum winning count for a valid colour.
REQ-006 Port: clk  in  1  system clock; all logic rising-edge.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: start  in  1  single-cycle request to begin a sweep; ignored while busy.
REQ-009 Port: continuous  in  1  when high, a new sweep starts automatically after each result.
REQ-010 Port: sensor_freq  in  1  asynchronous square wave from the sensor.
REQ-011 Port: scale  out  2  S0/S1 scaling select.
REQ-012 Port: filter  out  2  S2/S3 select: 00 red, 01 blue, 11 green, 10 clear.
REQ-013 Port: oe_n  out  1  sensor output enable, active-low.
REQ-014 Port: red_cnt, blue_cnt, green_cnt, clear_cnt  out  CNT_W each  latched window counts.
REQ-015 Port: color  out  3  one-hot result: 001 red, 010 blue, 100 green, 000 none.
REQ-016 Port: valid  out  1  one-cycle pulse when color and all counts are updated.
REQ-017 Port: busy  out  1  high from the sweep's first SETTLE cycle through CLASSIFY.
REQ-018 Port: sat  out  1  high when any count in the last sweep saturated.

Function
REQ-019 sensor_freq SHALL pass a 2-flop synchroniser followed by rising-edge detection; one edge pulse per sensor rising edge.
REQ-020 FSM states SHALL be IDLE, SETTLE, GATE, CLASSIFY; channel order red, blue, green, clear.
REQ-021 IDLE -> SETTLE(red) on start=1; filter=00 on the SETTLE entry cycle.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, count nothing, then go to GATE on the same channel.
REQ-023 GATE SHALL last exactly GATE_CYCLES cycles, incrementing the active channel counter on each cycle with an edge pulse.
REQ-024 At GATE end: red->SETTLE(blue), blue->SETTLE(green), green->SETTLE(clear), clear->CLASSIFY; each channel counter is cleared at its own GATE entry.
REQ-025 Counters SHALL saturate at 2^CNT_W-1; saturation sets the sweep's sat flag, with no wrap-around.
REQ-026 CLASSIFY (1 cycle): winner = channel among red/blue/green with count strictly greater than both others and >= MIN_CNT; otherwise color=000; clear never wins.
REQ-027 Counts, color and sat outputs SHALL update and valid pulse the cycle after CLASSIFY; outputs hold until the next valid.
REQ-028 After CLASSIFY: continuous=1 -> SETTLE(red), otherwise IDLE; start during a sweep has no effect.
REQ-029 oe_n SHALL be 0 and scale SHALL equal SCALE_SEL while busy; in IDLE oe_n=1 and scale=00 (power-down).
REQ-030 Sweep latency from start to valid SHALL be 4*(SETTLE_CYCLES+GATE_CYCLES)+2 cycles.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge, from any state including mid-GATE, discarding partial counts.
REQ-032 Reset values: scale=00, filter=00, oe_n=1, all counts 0, color=000, valid=0, busy=0, sat=0, synchroniser flops 0.
REQ-033 start asserted together with reset SHALL be ignored.

Structure
REQ-034 Package color_pkg SHALL hold filter encodings, color codes and the FSM state enum.
REQ-035 Synchroniser plus edge detector SHALL be sub-module freq_edge_sync (clk, reset, async_in, edge_pulse).

Verification (GATE_CYCLES=100, SETTLE_CYCLES=4, MIN_CNT=5, CNT_W=8)
REQ-036 Red 40, blue 10, green 12, clear 60 edges per window -> valid at start+418, color=001, red_cnt=40, sat=0.
REQ-037 Red 10, blue 10, green 10 -> color=000 (tie); green 4 only, others 0 -> color=000 (below MIN_CNT).
REQ-038 Sensor toggling every clk (edge every 2 cycles, 50 per window) with CNT_W=5 -> counts stop at 31, sat=1, no wrap.
REQ-039 reset pulsed mid-blue GATE -> next cycle oe_n=1, busy=0, IDLE; subsequent start gives a clean full sweep.
REQ-040 continuous=1, two sweeps -> valid pulses exactly 418 cycles apart, busy never drops, start mid-sweep ignored.

Source files
------------

// File: rtl/color_pkg.sv
// Shared encodings for the colour sensor controller: FSM states, channel
// order, sensor filter selects and one-hot colour result codes.
package color_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_CLASSIFY
    } state_t;

    // Sweep order; the enum value doubles as the counter index.
    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_BLUE  = 2'd1,
        CH_GREEN = 2'd2,
        CH_CLEAR = 2'd3
    } chan_t;

    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    localparam logic [2:0] COLOR_NONE  = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;
    localparam logic [2:0] COLOR_GREEN = 3'b100;

    function automatic logic [1:0] filter_of(input chan_t ch);
        logic [1:0] f;
        f = FILT_RED;
        case (ch)
            CH_RED:   f = FILT_RED;
            CH_BLUE:  f = FILT_BLUE;
            CH_GREEN: f = FILT_GREEN;
            CH_CLEAR: f = FILT_CLEAR;
            default:  f = FILT_RED;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/freq_edge_sync.sv
// Brings the asynchronous sensor square wave into the clk domain and emits
// one single-cycle pulse per rising edge.
module freq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/color_sensor_ctrl.sv
// Colour sensor sweep controller: settles and gates each filter channel in
// turn, counts sensor edges, then classifies the dominant colour.
module color_sensor_ctrl
    import color_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_CYCLES   = 50000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter logic [1:0]  SCALE_SEL     = 2'b01,
    parameter int unsigned MIN_CNT       = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic             sensor_freq,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic             oe_n,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [2:0]       color,
    output logic             valid,
    output logic             busy,
    output logic             sat
);

    localparam int unsigned PH_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  GATE_LAST   = PH_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_V       = CNT_W'(MIN_CNT);

    state_t           state_q, state_d;
    chan_t            chan_q, chan_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             hold_q, hold_d;
    logic             gate_entry;
    logic             sweep_entry;
    logic             edge_pulse;
    logic [CNT_W-1:0] cnt_q [4];
    logic             sat_acc_q;
    logic [2:0]       color_d;

    freq_edge_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (sensor_freq),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            chan_q  <= CH_RED;
            phase_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end

    // An automatic restart spends the result cycle in SETTLE(red) as an extra
    // hold cycle, so back-to-back sweeps repeat at the start-to-valid period.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        phase_d     = phase_q + 1'b1;
        hold_d      = 1'b0;
        gate_entry  = 1'b0;
        sweep_entry = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                chan_d  = CH_RED;
                if (start) begin
                    state_d     = ST_SETTLE;
                    sweep_entry = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (hold_q) begin
                    phase_d = phase_q;
                end else if (phase_q == SETTLE_LAST) begin
                    state_d    = ST_GATE;
                    phase_d    = '0;
                    gate_entry = 1'b1;
                end
            end
            ST_GATE: begin
                if (phase_q == GATE_LAST) begin
                    phase_d = '0;
                    if (chan_q == CH_CLEAR) begin
                        state_d = ST_CLASSIFY;
                    end else begin
                        state_d = ST_SETTLE;
                        chan_d  = chan_t'(chan_q + 2'd1);
                    end
                end
            end
            ST_CLASSIFY: begin
                phase_d = '0;
                chan_d  = CH_RED;
                if (continuous) begin
                    state_d     = ST_SETTLE;
                    hold_d      = 1'b1;
                    sweep_entry = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
            sat_acc_q <= 1'b0;
        end else begin
            if (sweep_entry) sat_acc_q <= 1'b0;
            if (gate_entry) begin
                cnt_q[chan_q] <= '0;
            end else if (state_q == ST_GATE && edge_pulse) begin
                if (cnt_q[chan_q] == CNT_MAX) sat_acc_q <= 1'b1;
                else cnt_q[chan_q] <= cnt_q[chan_q] + 1'b1;
            end
        end
    end

    // Clear is measured but never eligible to win.
    always_comb begin
        color_d = COLOR_NONE;
        if (cnt_q[CH_RED] > cnt_q[CH_BLUE] && cnt_q[CH_RED] > cnt_q[CH_GREEN]
            && cnt_q[CH_RED] >= MIN_V)
            color_d = COLOR_RED;
        else if (cnt_q[CH_BLUE] > cnt_q[CH_RED] && cnt_q[CH_BLUE] > cnt_q[CH_GREEN]
            && cnt_q[CH_BLUE] >= MIN_V)
            color_d = COLOR_BLUE;
        else if (cnt_q[CH_GREEN] > cnt_q[CH_RED] && cnt_q[CH_GREEN] > cnt_q[CH_BLUE]
            && cnt_q[CH_GREEN] >= MIN_V)
            color_d = COLOR_GREEN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red_cnt   <= '0;
            blue_cnt  <= '0;
            green_cnt <= '0;
            clear_cnt <= '0;
            color     <= COLOR_NONE;
            sat       <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= (state_q == ST_CLASSIFY);
            if (state_q == ST_CLASSIFY) begin
                red_cnt   <= cnt_q[CH_RED];
                blue_cnt  <= cnt_q[CH_BLUE];
                green_cnt <= cnt_q[CH_GREEN];
                clear_cnt <= cnt_q[CH_CLEAR];
                color     <= color_d;
                sat       <= sat_acc_q;
            end
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign oe_n   = ~busy;
    assign scale  = busy ? SCALE_SEL : 2'b00;
    assign filter = busy ? filter_of(chan_q) : FILT_RED;

endmodule
